sa_sequencer: RTL and testbench
===============================

SA_SEQUENCER -- requirements
Module: sa_sequencer

Interface
REQ-001 Parameter: N, 4, systolic array dimension (N x N PEs); legal range 2..16.
REQ-002 Parameter (derived localparam): STEP_W, clog2(3N-2), width of feed step counter.
REQ-003 Port: clk  input  1  single system clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: switch  input  1  asynchronous start request from board switch; rising edge starts one matrix multiply.
REQ-006 Port: clr_acc  output  1  clear all PE accumulators.
REQ-007 Port: feed_en  output  1  operand feed phase active; array shifts operands this cycle.
REQ-008 Port: step  output  STEP_W  current feed step t, 0..3N-3.
REQ-009 Port: row_valid  output  N  bit i = A-row i injects element k = t-i this cycle.
REQ-010 Port: col_valid  output  N  bit j = B-column j injects element k = t-j this cycle.
REQ-011 Port: res_wr_en  output  1  write one result row to result buffer.
REQ-012 Port: res_row  output  clog2(N)  result row index being written.
REQ-013 Port: busy  output  1  high in any state except IDLE and DONE.
REQ-014 Port: all_done  output  1  high while in DONE.

Function
REQ-015 switch SHALL pass through two synchronizer flops (s1, s2) and a history flop (prev); start pulse = s2 & ~prev.
REQ-016 States SHALL be IDLE, CLEAR, FEED, WRITE, DONE.
REQ-017 IDLE -> CLEAR on start pulse; otherwise hold.
REQ-018 CLEAR SHALL last exactly 1 cycle with clr_acc=1, then -> FEED with step=0.
REQ-019 FEED SHALL last exactly 3N-2 cycles, step incrementing 0..3N-3, feed_en=1; -> WRITE after step 3N-3.
REQ-020 In FEED, row_valid[i] = (i <= t < i+N); col_valid[j] = (j <= t < j+N); both 0 outside FEED.
REQ-021 WRITE SHALL last exactly N cycles, res_wr_en=1, res_row 0..N-1 ascending; -> DONE after row N-1.
REQ-022 DONE: all_done=1, held until reset or a new start pulse; start pulse in DONE -> CLEAR (all_done low the next cycle).
REQ-023 Start pulses in CLEAR, FEED or WRITE SHALL be ignored and not queued.
REQ-024 step, res_row SHALL be 0 outside their own phase; no counter wraps beyond its phase limit.
REQ-025 All outputs SHALL be registered (driven from state/counter flops, no combinational path from switch).

Reset
REQ-026 reset=1 at a clock edge SHALL force IDLE, clear all counters, and drive all outputs 0 by the next cycle, including mid-FEED or mid-WRITE.
REQ-027 reset SHALL load s1, s2, prev to 1 so a switch held high through reset does not start a run; a later 0->1 transition does.
REQ-028 reset SHALL take priority over a simultaneous start pulse.

Structure
REQ-029 Shared package sa_pkg SHALL hold default N, state encoding constants, and the clog2 helper for STEP_W / res_row width.
REQ-030 One sub-module sa_start_sync SHALL implement REQ-015/REQ-027 (synchronizer + edge detect); the FSM and counters live in sa_sequencer.

Verification (N=4, cycle 0 = first edge sampling switch=1)
REQ-031 Reset then switch 0->1 at cycle 0 -> clr_acc=1 in the cycle after edge 2, feed_en=1 for edges 3..12 (10 cycles), res_wr_en=1 for edges 13..16, all_done=1 from edge 17 onward.
REQ-032 During FEED at t=0, row_valid=col_valid=4'b0001; t=3: 4'b1111; t=6: 4'b1000; t=9: 4'b0000.
REQ-033 Second switch pulse during FEED (t=5) -> no effect; sequence timing identical to REQ-031; single all_done.
REQ-034 reset asserted at t=4 of FEED -> next cycle all outputs 0, state IDLE; next switch edge runs a full sequence.
REQ-035 switch held high across reset deassert -> no run; release and re-raise -> run starts per REQ-031 timing.
REQ-036 switch pulse while all_done=1 -> all_done low next cycle, full new sequence, all_done re-asserted after 18 cycles.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array sequencer: default array size,
// controller state encoding and the width helper used for counter sizing.
package sa_pkg;

   localparam int unsigned SA_N_DEFAULT = 4;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_FEED  = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4
   } sa_state_e;

   function automatic int unsigned sa_clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r++;
      return r;
   endfunction

endpackage

// File: rtl/sa_sequencer_if.sv
// Control bundle from the sequencer to the systolic array and result buffer.
interface sa_sequencer_if
   import sa_pkg::*;
#(
   parameter int unsigned N = SA_N_DEFAULT
);
   localparam int unsigned STEP_W = sa_clog2(3 * N - 2);
   localparam int unsigned ROW_W  = sa_clog2(N);

   logic              clr_acc;
   logic              feed_en;
   logic [STEP_W-1:0] step;
   logic [N-1:0]      row_valid;
   logic [N-1:0]      col_valid;
   logic              res_wr_en;
   logic [ROW_W-1:0]  res_row;
   logic              busy;
   logic              all_done;

   modport master (
      output clr_acc, feed_en, step, row_valid, col_valid,
             res_wr_en, res_row, busy, all_done
   );

   modport slave (
      input  clr_acc, feed_en, step, row_valid, col_valid,
             res_wr_en, res_row, busy, all_done
   );

endinterface

// File: rtl/sa_start_sync.sv
// Two-flop synchronizer for the board switch plus rising-edge detector.
module sa_start_sync (
   input  logic clk,
   input  logic reset,
   input  logic switch,
   output logic start
);

   logic s1, s2, prev;

   // Loading ones on reset means a switch already high cannot look like a new edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1   <= 1'b1;
         s2   <= 1'b1;
         prev <= 1'b1;
      end else begin
         s1   <= switch;
         s2   <= s1;
         prev <= s2;
      end
   end

   assign start = s2 & ~prev;

endmodule

// File: rtl/sa_sequencer.sv
// Systolic-array sequencer: clear accumulators, skew-feed operands for 3N-2
// steps, then write N result rows; one run per rising edge of the switch.
module sa_sequencer
   import sa_pkg::*;
#(
   parameter int unsigned N = SA_N_DEFAULT
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           switch,
   sa_sequencer_if.master seq
);

   localparam int unsigned STEP_W = sa_clog2(3 * N - 2);
   localparam int unsigned ROW_W  = sa_clog2(N);
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(3 * N - 3);
   localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(N - 1);

   logic              start;
   sa_state_e         state_q, state_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic [N-1:0]      valid;

   sa_start_sync u_start_sync (
      .clk    (clk),
      .reset  (reset),
      .switch (switch),
      .start  (start)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         step_q  <= '0;
         row_q   <= '0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         row_q   <= row_d;
      end
   end

   // Counters default to zero so they read 0 in every state but their own.
   always_comb begin
      state_d = state_q;
      step_d  = '0;
      row_d   = '0;
      unique case (state_q)
         S_IDLE:  if (start) state_d = S_CLEAR;
         S_CLEAR: state_d = S_FEED;
         S_FEED: begin
            if (step_q == STEP_LAST) state_d = S_WRITE;
            else                     step_d  = step_q + 1'b1;
         end
         S_WRITE: begin
            if (row_q == ROW_LAST) state_d = S_DONE;
            else                   row_d   = row_q + 1'b1;
         end
         S_DONE:  if (start) state_d = S_CLEAR;
         default: state_d = S_IDLE;
      endcase
   end

   // Lane i is active while its skewed window i <= t < i+N covers the step.
   always_comb begin
      valid = '0;
      if (state_q == S_FEED) begin
         for (int unsigned i = 0; i < N; i++) begin
            if (32'(step_q) >= i && 32'(step_q) < i + N) valid[i] = 1'b1;
         end
      end
   end

   assign seq.clr_acc   = (state_q == S_CLEAR);
   assign seq.feed_en   = (state_q == S_FEED);
   assign seq.step      = step_q;
   assign seq.row_valid = valid;
   assign seq.col_valid = valid;
   assign seq.res_wr_en = (state_q == S_WRITE);
   assign seq.res_row   = row_q;
   assign seq.busy      = (state_q == S_CLEAR) || (state_q == S_FEED) || (state_q == S_WRITE);
   assign seq.all_done  = (state_q == S_DONE);

endmodule

// File: tb/tb_sa_sequencer.sv
// Self-checking bench for sa_sequencer: run-phase reference model plus
// directed timing pins and randomized switch/reset stimulus.
module tb_sa_sequencer;
   import sa_pkg::*;

   localparam int unsigned N = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic switch = 1'b0;

   int unsigned tests = 0;
   int unsigned fails = 0;
   int          cyc = 0;

   sa_sequencer_if #(.N(N)) sif ();

   sa_sequencer #(.N(N)) dut (
      .clk    (clk),
      .reset  (reset),
      .switch (switch),
      .seq    (sif)
   );

   always #5 clk = ~clk;

   // Reference model: m_c counts cycles since the run's CLEAR cycle.
   bit       checking = 0;
   bit       m_active = 0;
   bit       m_done = 0;
   int       m_c = 0;
   bit [2:0] hist = 3'b111;   // switch samples at edges E-1, E-2, E-3

   initial forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
         checking = 1;
         m_active = 0;
         m_done   = 0;
         m_c      = 0;
         hist     = 3'b111;
      end else begin
         if (m_active) begin
            m_c++;
            if (m_c == int'(4 * N - 1)) begin
               m_active = 0;
               m_done   = 1;
            end
         end else if (hist[1] && !hist[2]) begin
            m_active = 1;
            m_done   = 0;
            m_c      = 0;
         end
         hist = {hist[1:0], switch};
      end
   end

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   initial forever begin
      @(negedge clk);
      if (checking) begin
         int          t;
         bit          e_feed, e_wr;
         int unsigned e_valid;
         t       = m_c - 1;
         e_feed  = m_active && m_c >= 1 && m_c <= int'(3 * N - 2);
         e_wr    = m_active && m_c >= int'(3 * N - 1);
         e_valid = 0;
         if (e_feed)
            for (int i = 0; i < int'(N); i++)
               if (t >= i && t < i + int'(N)) e_valid |= (32'd1 << i);
         check("clr_acc",   32'(sif.clr_acc),   32'(m_active && m_c == 0));
         check("feed_en",   32'(sif.feed_en),   32'(e_feed));
         check("step",      32'(sif.step),      e_feed ? 32'(t) : 0);
         check("row_valid", 32'(sif.row_valid), e_valid);
         check("col_valid", 32'(sif.col_valid), e_valid);
         check("res_wr_en", 32'(sif.res_wr_en), 32'(e_wr));
         check("res_row",   32'(sif.res_row),   e_wr ? 32'(m_c - int'(3 * N - 1)) : 0);
         check("busy",      32'(sif.busy),      32'(m_active));
         check("all_done",  32'(sif.all_done),  32'(m_done));
      end
   end

   task automatic wait_cyc(input int k);
      while (cyc < k) @(negedge clk);
   endtask

   task automatic check_all_zero(input string name);
      check(name, 32'({sif.clr_acc, sif.feed_en, sif.step, sif.row_valid, sif.col_valid,
                       sif.res_wr_en, sif.res_row, sif.busy, sif.all_done}), 0);
   endtask

   initial begin
      int e0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_all_zero("reset_state");

      // Basic run, with a second pulse during FEED that must be ignored.
      switch = 1'b1;
      e0 = cyc + 1;
      wait_cyc(e0 + 1);  check("pin_clr_before", 32'(sif.clr_acc), 0);
      wait_cyc(e0 + 2);  check("pin_clr", 32'(sif.clr_acc), 1);
      wait_cyc(e0 + 3);  check("pin_t0_valid", 32'(sif.row_valid), 32'h1);
      switch = 1'b0;
      wait_cyc(e0 + 6);  check("pin_t3_valid", 32'(sif.col_valid), 32'hF);
      wait_cyc(e0 + 7);  switch = 1'b1;
      wait_cyc(e0 + 9);  check("pin_t6_valid", 32'(sif.row_valid), 32'h8);
      switch = 1'b0;
      wait_cyc(e0 + 12); check("pin_t9_valid", 32'(sif.row_valid), 32'h0);
      check("pin_t9_feed", 32'(sif.feed_en), 1);
      check("pin_t9_step", 32'(sif.step), 9);
      wait_cyc(e0 + 13); check("pin_wr_row0", 32'({sif.res_wr_en, sif.res_row}), 32'b100);
      wait_cyc(e0 + 16); check("pin_wr_row3", 32'({sif.res_wr_en, sif.res_row}), 32'b111);
      wait_cyc(e0 + 17); check("pin_done", 32'(sif.all_done), 1);
      wait_cyc(e0 + 30); check("pin_done_held", 32'({sif.all_done, sif.busy}), 32'b10);

      // New start from DONE.
      switch = 1'b1;
      e0 = cyc + 1;
      wait_cyc(e0 + 2);  check("pin_redo_clr", 32'({sif.all_done, sif.clr_acc}), 32'b01);
      switch = 1'b0;
      wait_cyc(e0 + 16); check("pin_redo_notdone", 32'(sif.all_done), 0);
      wait_cyc(e0 + 17); check("pin_redo_done", 32'(sif.all_done), 1);

      // Reset in the middle of FEED.
      switch = 1'b1;
      e0 = cyc + 1;
      wait_cyc(e0 + 7);  check("pin_mid_feed", 32'(sif.step), 4);
      reset = 1'b1;
      wait_cyc(e0 + 8);  check_all_zero("pin_mid_reset");
      reset = 1'b0;
      switch = 1'b0;
      repeat (4) @(negedge clk);
      switch = 1'b1;
      e0 = cyc + 1;
      wait_cyc(e0 + 2);  check("pin_after_reset_clr", 32'(sif.clr_acc), 1);
      wait_cyc(e0 + 17); check("pin_after_reset_done", 32'(sif.all_done), 1);

      // Switch held high across reset must not start a run.
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (25) @(negedge clk);
      check("pin_held_no_run", 32'({sif.busy, sif.all_done}), 0);
      switch = 1'b0;
      repeat (3) @(negedge clk);
      switch = 1'b1;
      e0 = cyc + 1;
      wait_cyc(e0 + 2);  check("pin_rearm_clr", 32'(sif.clr_acc), 1);
      wait_cyc(e0 + 3);  check("pin_rearm_feed", 32'(sif.feed_en), 1);

      // Randomized switch activity with occasional resets.
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         reset = ($urandom_range(0, 249) == 0);
         if ($urandom_range(0, 7) == 0) switch = ~switch;
      end
      reset = 1'b0;
      repeat (2) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
